// File: rtl/sifive_int_gw_pkg.sv
// Shared types and defaults for the per-line interrupt gateway.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sifive_int_gw_pkg;

    // Per-line request state; encoding is fixed so state values stay stable across revisions.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        INFL = 2'd2
    } gw_state_e;

    // Default width of the per-line edge backlog counter.
    localparam int GW_CNT_W_DEF = 2;

endpackage

// File: rtl/sifive_int_gw_line.sv
// One interrupt line: synchroniser, edge detect, IDLE/PEND/INFL FSM, edge backlog counter.
// Latency: src stable before edge k -> pending after edge k+SYNC_STAGES; claim/complete act on next edge.
// Backpressure: request held in PEND until claimed; edges during PEND/INFL queue in a saturating backlog.
module sifive_int_gw_line
    import sifive_int_gw_pkg::*;
#(
    parameter bit EDGE        = 1'b0,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = GW_CNT_W_DEF
) (
    input  logic clock,
    input  logic reset_n,
    input  logic src_i,
    input  logic claim_i,
    input  logic complete_i,
    input  logic ovf_clr_i,
    output logic pending_o,
    output logic busy_o,
    output logic ovf_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    gw_state_e              r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_pending;
    logic                   r_busy;
    logic                   r_ovf;

    logic                   w_sync;
    logic                   w_rise;
    logic                   w_cnt_nz;
    logic                   w_req;
    gw_state_e              w_state_nxt;
    logic                   w_inc;
    logic                   w_dec;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_ovf_set;

    assign w_sync   = r_sync[SYNC_STAGES-1];
    assign w_rise   = w_sync & ~r_prev;
    assign w_cnt_nz = (r_cnt != '0);

    // Plain flop synchroniser plus one-cycle history for rising-edge detection.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], src_i};
            r_prev <= w_sync;
        end
    end

    // Next-state decode: level lines request on the synced level, edge lines on a rise or a queued edge.
    always_comb begin
        w_state_nxt = r_state;
        w_req       = EDGE ? (w_rise | w_cnt_nz) : w_sync;
        case (r_state)
            IDLE:    if (w_req)      w_state_nxt = PEND;
            PEND:    if (claim_i)    w_state_nxt = INFL;
            INFL:    if (complete_i) w_state_nxt = w_cnt_nz ? PEND : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register; outputs are registered from the next state so they never glitch.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_pending <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= (w_state_nxt == PEND);
            r_busy    <= (w_state_nxt == INFL);
        end
    end

    // Backlog update: an edge and a re-arming complete in the same cycle cancel out.
    always_comb begin
        w_inc     = EDGE & w_rise & ((r_state == PEND) | (r_state == INFL));
        w_dec     = EDGE & (r_state == INFL) & complete_i & w_cnt_nz;
        w_cnt_nxt = r_cnt;
        w_ovf_set = 1'b0;
        if (w_inc && !w_dec) begin
            if (r_cnt == CNT_MAX) begin
                w_ovf_set = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end else if (w_dec && !w_inc) begin
            w_cnt_nxt = r_cnt - 1'b1;
        end
    end

    // Counter and sticky overflow; a lost edge beats a simultaneous clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr_i) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign pending_o = r_pending;
    assign busy_o    = r_busy;
    assign ovf_o     = r_ovf;

endmodule

// File: rtl/sifive_int_gateway.sv
// Interrupt gateway: N_SRC independent lines, each level- or edge-qualified by EDGE_MASK.
// Latency: SYNC_STAGES edges from stable source to pending; one edge for claim/complete.
// Backpressure: each line holds its request until claimed and completed; ovf_o flags lost edges.
module sifive_int_gateway
    import sifive_int_gw_pkg::*;
#(
    parameter int               N_SRC       = 4,
    parameter int               SYNC_STAGES = 2,
    parameter logic [N_SRC-1:0] EDGE_MASK   = {N_SRC{1'b0}},
    parameter int               CNT_W       = GW_CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [N_SRC-1:0] src_i,
    input  logic [N_SRC-1:0] claim_i,
    input  logic [N_SRC-1:0] complete_i,
    input  logic             ovf_clr_i,
    output logic [N_SRC-1:0] pending_o,
    output logic [N_SRC-1:0] busy_o,
    output logic [N_SRC-1:0] ovf_o
);

    logic w_ovf_clr;

    assign w_ovf_clr = ovf_clr_i;

    for (genvar g = 0; g < N_SRC; g++) begin : g_line
        sifive_int_gw_line #(
            .EDGE        (EDGE_MASK[g]),
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W)
        ) u_line (
            .clock      (clock),
            .reset_n    (reset_n),
            .src_i      (src_i[g]),
            .claim_i    (claim_i[g]),
            .complete_i (complete_i[g]),
            .ovf_clr_i  (w_ovf_clr),
            .pending_o  (pending_o[g]),
            .busy_o     (busy_o[g]),
            .ovf_o      (ovf_o[g])
        );
    end

endmodule

// File: tb/tb_sifive_int_gateway.sv
// Directed bench for sifive_int_gateway: lines 0/2 level, lines 1/3 edge.
// Each step drives inputs at negedge, clocks one posedge, compares at the next negedge.
// Expected values are hand-derived from the gateway behaviour.
module tb_sifive_int_gateway;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] src = '0;
    logic [3:0] claim = '0;
    logic [3:0] comp = '0;
    logic       clr = 1'b0;
    logic [3:0] pend;
    logic [3:0] busy;
    logic [3:0] ovf;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0] s;
        logic [3:0] c;
        logic [3:0] k;
        logic       clr;
        logic [3:0] ep;
        logic [3:0] eb;
        logic [3:0] eo;
    } vec_t;

    vec_t vecs[$];

    sifive_int_gateway #(
        .N_SRC       (4),
        .SYNC_STAGES (2),
        .EDGE_MASK   (4'b1010),
        .CNT_W       (2)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .src_i      (src),
        .claim_i    (claim),
        .complete_i (comp),
        .ovf_clr_i  (clr),
        .pending_o  (pend),
        .busy_o     (busy),
        .ovf_o      (ovf)
    );

    initial forever #5 clock = ~clock;

    function automatic vec_t mk(input logic [3:0] s, input logic [3:0] c, input logic [3:0] k,
                                input logic cl, input logic [3:0] ep, input logic [3:0] eb,
                                input logic [3:0] eo);
        vec_t v;
        v.s = s; v.c = c; v.k = k; v.clr = cl; v.ep = ep; v.eb = eb; v.eo = eo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] ep, input logic [3:0] eb,
                           input logic [3:0] eo);
        chk({tag, ".pend"}, pend, ep);
        chk({tag, ".busy"}, busy, eb);
        chk({tag, ".ovf"},  ovf,  eo);
    endtask

    task automatic step(input logic [3:0] s, input logic [3:0] c, input logic [3:0] k,
                        input logic cl);
        src = s; claim = c; comp = k; clr = cl;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        step(v.s, v.c, v.k, v.clr);
        chk_all(tag, v.ep, v.eb, v.eo);
    endtask

    initial begin
        // Level line 0: sync latency, claim, complete with src still high re-pends next cycle.
        vecs.push_back(mk(4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(4'h1, 4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(4'h1, 4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(4'h1, 4'h0, 4'h0, 0, 4'h1, 4'h0, 4'h0));
        vecs.push_back(mk(4'h1, 4'h1, 4'h0, 0, 4'h0, 4'h1, 4'h0));
        vecs.push_back(mk(4'h1, 4'h0, 4'h0, 0, 4'h0, 4'h1, 4'h0));
        vecs.push_back(mk(4'h1, 4'h0, 4'h1, 0, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(4'h1, 4'h0, 4'h0, 0, 4'h1, 4'h0, 4'h0));
        vecs.push_back(mk(4'h0, 4'h1, 4'h0, 0, 4'h0, 4'h1, 4'h0));
        vecs.push_back(mk(4'h0, 4'h0, 4'h1, 0, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h0));
        // Line 2: claim in IDLE and complete in PEND are ignored.
        vecs.push_back(mk(4'h0, 4'h4, 4'h4, 0, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(4'h4, 4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(4'h4, 4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(4'h4, 4'h0, 4'h0, 0, 4'h4, 4'h0, 4'h0));
        vecs.push_back(mk(4'h4, 4'h0, 4'h4, 0, 4'h4, 4'h0, 4'h0));
        vecs.push_back(mk(4'h0, 4'h4, 4'h0, 0, 4'h0, 4'h4, 4'h0));
        vecs.push_back(mk(4'h0, 4'h0, 4'h4, 0, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h0));
        // Edge line 1: three edges in INFL fill the backlog, a fourth overflows.
        vecs.push_back(mk(4'h2, 4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(4'h0, 4'h0, 4'h0, 0, 4'h2, 4'h0, 4'h0));
        vecs.push_back(mk(4'h0, 4'h2, 4'h0, 0, 4'h0, 4'h2, 4'h0));
        vecs.push_back(mk(4'h2, 4'h0, 4'h0, 0, 4'h0, 4'h2, 4'h0));
        vecs.push_back(mk(4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h2, 4'h0));
        vecs.push_back(mk(4'h2, 4'h0, 4'h0, 0, 4'h0, 4'h2, 4'h0));
        vecs.push_back(mk(4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h2, 4'h0));
        vecs.push_back(mk(4'h2, 4'h0, 4'h0, 0, 4'h0, 4'h2, 4'h0));
        vecs.push_back(mk(4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h2, 4'h0));
        vecs.push_back(mk(4'h2, 4'h0, 4'h0, 0, 4'h0, 4'h2, 4'h0));
        vecs.push_back(mk(4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h2, 4'h0));
        vecs.push_back(mk(4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h2, 4'h2));
        // Drain: three completes re-pend, the fourth idles; then clear overflow.
        vecs.push_back(mk(4'h0, 4'h0, 4'h2, 0, 4'h2, 4'h0, 4'h2));
        vecs.push_back(mk(4'h0, 4'h2, 4'h0, 0, 4'h0, 4'h2, 4'h2));
        vecs.push_back(mk(4'h0, 4'h0, 4'h2, 0, 4'h2, 4'h0, 4'h2));
        vecs.push_back(mk(4'h0, 4'h2, 4'h0, 0, 4'h0, 4'h2, 4'h2));
        vecs.push_back(mk(4'h0, 4'h0, 4'h2, 0, 4'h2, 4'h0, 4'h2));
        vecs.push_back(mk(4'h0, 4'h2, 4'h0, 0, 4'h0, 4'h2, 4'h2));
        vecs.push_back(mk(4'h0, 4'h0, 4'h2, 0, 4'h0, 4'h0, 4'h2));
        vecs.push_back(mk(4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h2));
        vecs.push_back(mk(4'h0, 4'h0, 4'h0, 1, 4'h0, 4'h0, 4'h0));
        // Edge line 1: edge and complete together with backlog 1 -> PEND, backlog stays 1.
        vecs.push_back(mk(4'h2, 4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(4'h0, 4'h0, 4'h0, 0, 4'h2, 4'h0, 4'h0));
        vecs.push_back(mk(4'h0, 4'h2, 4'h0, 0, 4'h0, 4'h2, 4'h0));
        vecs.push_back(mk(4'h2, 4'h0, 4'h0, 0, 4'h0, 4'h2, 4'h0));
        vecs.push_back(mk(4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h2, 4'h0));
        vecs.push_back(mk(4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h2, 4'h0));
        vecs.push_back(mk(4'h2, 4'h0, 4'h0, 0, 4'h0, 4'h2, 4'h0));
        vecs.push_back(mk(4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h2, 4'h0));
        vecs.push_back(mk(4'h0, 4'h0, 4'h2, 0, 4'h2, 4'h0, 4'h0));
        vecs.push_back(mk(4'h0, 4'h2, 4'h0, 0, 4'h0, 4'h2, 4'h0));
        vecs.push_back(mk(4'h0, 4'h0, 4'h2, 0, 4'h2, 4'h0, 4'h0));
        vecs.push_back(mk(4'h0, 4'h2, 4'h0, 0, 4'h0, 4'h2, 4'h0));
        vecs.push_back(mk(4'h0, 4'h0, 4'h2, 0, 4'h0, 4'h0, 4'h0));
        vecs.push_back(mk(4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h0));

        // Reset state.
        @(negedge clock);
        chk_all("reset", 4'h0, 4'h0, 4'h0);
        @(posedge clock);
        @(negedge clock);
        chk_all("reset_hold", 4'h0, 4'h0, 4'h0);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec($sformatf("tbl[%0d]", i), vecs[i]);
        end

        // Clear coinciding with a saturating edge: overflow wins, then a lone clear drops it.
        step(4'h2, 4'h0, 4'h0, 0);
        step(4'h0, 4'h0, 4'h0, 0);
        step(4'h0, 4'h0, 4'h0, 0);
        chk_all("clr.pend", 4'h2, 4'h0, 4'h0);
        step(4'h0, 4'h2, 4'h0, 0);
        chk_all("clr.claim", 4'h0, 4'h2, 4'h0);
        for (int p = 0; p < 4; p++) begin
            step(4'h2, 4'h0, 4'h0, 0);
            chk_all($sformatf("clr.hi%0d", p), 4'h0, 4'h2, 4'h0);
            step(4'h0, 4'h0, 4'h0, 0);
            chk_all($sformatf("clr.lo%0d", p), 4'h0, 4'h2, 4'h0);
        end
        step(4'h0, 4'h0, 4'h0, 1);
        chk_all("clr.sat", 4'h0, 4'h2, 4'h2);
        step(4'h0, 4'h0, 4'h0, 1);
        chk_all("clr.alone", 4'h0, 4'h2, 4'h0);
        for (int d = 0; d < 3; d++) begin
            step(4'h0, 4'h0, 4'h2, 0);
            chk_all($sformatf("clr.cmp%0d", d), 4'h2, 4'h0, 4'h0);
            step(4'h0, 4'h2, 4'h0, 0);
            chk_all($sformatf("clr.clm%0d", d), 4'h0, 4'h2, 4'h0);
        end
        step(4'h0, 4'h0, 4'h2, 0);
        chk_all("clr.idle", 4'h0, 4'h0, 4'h0);

        // Reset while edge line 3 is INFL with backlog 2; source held high across release.
        step(4'h8, 4'h0, 4'h0, 0);
        step(4'h0, 4'h0, 4'h0, 0);
        step(4'h0, 4'h0, 4'h0, 0);
        chk_all("rst.pend", 4'h8, 4'h0, 4'h0);
        step(4'h0, 4'h8, 4'h0, 0);
        step(4'h8, 4'h0, 4'h0, 0);
        step(4'h0, 4'h0, 4'h0, 0);
        step(4'h8, 4'h0, 4'h0, 0);
        step(4'h0, 4'h0, 4'h0, 0);
        step(4'h8, 4'h0, 4'h0, 0);
        chk_all("rst.infl", 4'h0, 4'h8, 4'h0);
        reset_n = 1'b0;
        #1;
        chk_all("rst.async", 4'h0, 4'h0, 4'h0);
        @(posedge clock);
        @(negedge clock);
        chk_all("rst.held", 4'h0, 4'h0, 4'h0);
        reset_n = 1'b1;
        step(4'h8, 4'h0, 4'h0, 0);
        chk_all("rst.rel1", 4'h0, 4'h0, 4'h0);
        step(4'h8, 4'h0, 4'h0, 0);
        chk_all("rst.rel2", 4'h0, 4'h0, 4'h0);
        step(4'h8, 4'h0, 4'h0, 0);
        chk_all("rst.rel3", 4'h8, 4'h0, 4'h0);
        step(4'h8, 4'h8, 4'h0, 0);
        chk_all("rst.claim", 4'h0, 4'h8, 4'h0);
        step(4'h8, 4'h0, 4'h8, 0);
        chk_all("rst.nobacklog", 4'h0, 4'h0, 4'h0);
        step(4'h8, 4'h0, 4'h0, 0);
        chk_all("rst.noedge", 4'h0, 4'h0, 4'h0);
        step(4'h0, 4'h0, 4'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
